// File: rtl/iq_sync_fifo_pkg.sv
// Shared constants for the I/Q sample FIFO: complex word width, I/Q slice
// positions and default geometry.
package iq_sync_fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CH_WIDTH_DEF   = 2;

  // Complex sample is {I, Q}: I occupies the upper half.
  function automatic int iq_width(input int dw);
    return 2 * dw;
  endfunction

  function automatic int i_msb(input int dw);
    return 2 * dw - 1;
  endfunction

  function automatic int i_lsb(input int dw);
    return dw;
  endfunction

  function automatic int q_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int q_lsb(input int dw);
    return (dw > 0) ? 0 : 0;
  endfunction

endpackage

// File: rtl/iq_sync_fifo_if.sv
// Write/read/status bundle of iq_sync_fifo. The FIFO takes the slave view,
// the producer/consumer side takes the master view.
interface iq_sync_fifo_if
  import iq_sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CH_WIDTH   = CH_WIDTH_DEF
);
  localparam int IQW = iq_width(DATA_WIDTH);

  logic                  wr_en_i;
  logic [IQW-1:0]        wr_data_i;
  logic [CH_WIDTH-1:0]   wr_ch_i;
  logic                  rd_en_i;
  logic [IQW-1:0]        rd_data_o;
  logic [CH_WIDTH-1:0]   rd_ch_o;
  logic                  rd_valid_o;
  logic                  full_o;
  logic                  empty_o;
  logic [ADDR_WIDTH:0]   level_o;
  logic [ADDR_WIDTH:0]   af_thresh_i;
  logic [ADDR_WIDTH:0]   ae_thresh_i;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic                  clr_flags_i;

  modport master (
    output wr_en_i, wr_data_i, wr_ch_i, rd_en_i, af_thresh_i, ae_thresh_i, clr_flags_i,
    input  rd_data_o, rd_ch_o, rd_valid_o, full_o, empty_o, level_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, wr_ch_i, rd_en_i, af_thresh_i, ae_thresh_i, clr_flags_i,
    output rd_data_o, rd_ch_o, rd_valid_o, full_o, empty_o, level_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/iq_fifo_ram.sv
// Simple dual-port RAM with registered, enable-gated read and no reset so it
// maps onto block RAM. The read register holds while rd_en is low.
module iq_fifo_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 34
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO for channel-tagged I/Q words with occupancy, threshold and
// sticky error flags, in standard or first-word-fall-through read mode.
module iq_sync_fifo
  import iq_sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CH_WIDTH   = CH_WIDTH_DEF,
  parameter int FWFT       = 0
) (
  input  logic          clk_i,
  input  logic          rst_b_i,
  iq_sync_fifo_if.slave bus
);

  localparam int IQW   = iq_width(DATA_WIDTH);
  localparam int WIDTH = IQW + CH_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0]    wr_ptr, rd_ptr, ram_cnt;
  logic [PW-1:0]    level, level_nxt;
  logic             full, empty;
  logic             wr_acc, rd_acc, ram_rd_en;
  logic             af, ae, ov, un;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] out_w;
  logic             out_vld_w;

  assign wr_acc    = bus.wr_en_i & ~full;
  assign rd_acc    = bus.rd_en_i & ~empty;
  assign ram_cnt   = wr_ptr - rd_ptr;
  assign level_nxt = level + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};

  iq_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WIDTH     (WIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data({bus.wr_ch_i, bus.wr_data_i}),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(ram_q)
  );

  // Status flags are computed from the next level so they move with level_o.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      af     <= 1'b0;
      ae     <= 1'b1;
      ov     <= 1'b0;
      un     <= 1'b0;
    end else begin
      if (wr_acc)    wr_ptr <= wr_ptr + PONE;
      if (ram_rd_en) rd_ptr <= rd_ptr + PONE;
      level <= level_nxt;
      full  <= (level_nxt == DEPTH);
      af    <= (level_nxt >= bus.af_thresh_i);
      ae    <= (level_nxt <= bus.ae_thresh_i);
      ov    <= (bus.wr_en_i & full)  | (ov & ~bus.clr_flags_i);
      un    <= (bus.rd_en_i & empty) | (un & ~bus.clr_flags_i);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic             ram_vld, out_vld, pop, load, fetch;
      logic [1:0]       held;
      logic [WIDTH-1:0] out_q;

      // The RAM read register doubles as the skid stage: fetch only while
      // fewer than two words sit between the RAM and the consumer.
      assign pop   = bus.rd_en_i & out_vld;
      assign load  = ram_vld & (~out_vld | pop);
      assign held  = {1'b0, ram_vld} + {1'b0, out_vld} - {1'b0, pop};
      assign fetch = (ram_cnt != '0) & (held < 2'd2);

      always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
          ram_vld <= 1'b0;
          out_vld <= 1'b0;
          out_q   <= '0;
        end else begin
          if (fetch)     ram_vld <= 1'b1;
          else if (load) ram_vld <= 1'b0;
          if (load) begin
            out_vld <= 1'b1;
            out_q   <= ram_q;
          end else if (pop) begin
            out_vld <= 1'b0;
          end
        end
      end

      assign ram_rd_en = fetch;
      assign empty     = ~out_vld;
      assign out_w     = out_q;
      assign out_vld_w = out_vld;
    end else begin : g_std
      logic rvld, primed;

      always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
          rvld   <= 1'b0;
          primed <= 1'b0;
        end else begin
          rvld <= rd_acc;
          if (rd_acc) primed <= 1'b1;
        end
      end

      // Every stored word is still in RAM here, so the RAM count is the level.
      assign ram_rd_en = rd_acc;
      assign empty     = (ram_cnt == '0);
      assign out_w     = primed ? ram_q : '0;
      assign out_vld_w = rvld;
    end
  endgenerate

  assign bus.rd_data_o      = out_w[IQW-1:0];
  assign bus.rd_ch_o        = out_w[WIDTH-1:IQW];
  assign bus.rd_valid_o     = out_vld_w;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.level_o        = level;
  assign bus.almost_full_o  = af;
  assign bus.almost_empty_o = ae;
  assign bus.overflow_o     = ov;
  assign bus.underflow_o    = un;

endmodule

// File: doc/iq_sync_fifo.md
# iq_sync_fifo

Single-clock, parametrised FIFO for interleaved I/Q sample streams in the modem datapath. Stores full-depth complex words tagged with a channel index. Provides:
- registered occupancy and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between the per-channel sample mux and the host-side packetiser, where both sides share one clock.

## Interface
- ADDR_WIDTH, 10: log2 of depth; DEPTH = 2**ADDR_WIDTH entries, all usable.
- DATA_WIDTH, 16: width of each of I and Q.
- CH_WIDTH, 2: width of the channel tag stored with each word.
- FWFT, 0: 0 = standard read (data after rd_en_i); 1 = first-word-fall-through.

- clk_i  in  1  sole clock, rising edge.
- rst_b_i  in  1  reset, asynchronous assert, active-low.
- wr_en_i  in  1  write request.
- wr_data_i  in  2*DATA_WIDTH  {I, Q}, I in upper half.
- wr_ch_i  in  CH_WIDTH  channel tag for wr_data_i.
- rd_en_i  in  1  read request (FWFT: pop/acknowledge).
- rd_data_o  out  2*DATA_WIDTH  {I, Q} read word.
- rd_ch_o  out  CH_WIDTH  tag of rd_data_o.
- rd_valid_o  out  1  rd_data_o/rd_ch_o valid.
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  no word available to read.
- level_o  out  ADDR_WIDTH+1  occupancy.
- af_thresh_i  in  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh_i  in  ADDR_WIDTH+1  almost-empty threshold.
- almost_full_o  out  1  level_o >= af_thresh_i.
- almost_empty_o  out  1  level_o <= ae_thresh_i.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.
- clr_flags_i  in  1  synchronous clear of overflow_o/underflow_o.

## Operation
- **Pointers:** write and read pointers are ADDR_WIDTH+1 bits. The MSB distinguishes full from empty, so all DEPTH entries are usable. Pointers wrap modulo 2**(ADDR_WIDTH+1).
- **Write accept:** wr_acc = wr_en_i & ~full_o. An accepted write stores {wr_ch_i, wr_data_i} and increments the write pointer.
- **Write reject:** a rejected write (wr_en_i & full_o) leaves memory and pointers unchanged and sets overflow_o.
- **Read accept:** rd_acc = rd_en_i & ~empty_o. A rejected read sets underflow_o and changes nothing else.
- **Level:** level_o(next) = level_o + wr_acc − rd_acc. Simultaneous accepted read and write leave the level unchanged. This includes a read+write while full in FWFT mode, where the read frees the slot in the same cycle only if full_o is low; full_o gates the write regardless.
- **Standard mode (FWFT=0):**
  - empty_o = (level_o == 0).
  - An accepted read presents the head word on rd_data_o/rd_ch_o with rd_valid_o high for exactly one cycle.
  - rd_data_o holds its last value otherwise.
- **FWFT mode (FWFT=1):**
  - An internal prefetch moves the head word into the output register whenever that register is empty and the RAM holds data.
  - rd_valid_o is high while the output register holds a word; empty_o = ~rd_valid_o.
  - rd_en_i with rd_valid_o pops the word.
  - A back-to-back pop refills the output register the next cycle with no bubble when RAM data exists; a 1-deep skid register is allowed.
  - level_o counts words in the RAM plus the output register/skid.
- **Thresholds:** almost_full_o and almost_empty_o are registered comparisons against level_o(next), so they update in the same cycle as level_o. Threshold inputs are sampled each cycle.
- **Sticky flags:** overflow_o/underflow_o clear on clr_flags_i. A set event in the same cycle as clr_flags_i wins (flag stays 1).
- **Memory:** contents are never reset.

## Timing
- **Reset values:**
  - empty_o = 1, full_o = 0, level_o = 0;
  - rd_valid_o = 0, rd_data_o = 0, rd_ch_o = 0;
  - almost_full_o = 0, almost_empty_o = 1;
  - overflow_o = 0, underflow_o = 0.
- **Reset behaviour:** assertion is immediate (asynchronous). Release is sampled on clk_i.
- **Reset mid-operation:** all pointers and flags return to reset values; the next write after release is the first word out.
- **Status latency:** level_o, full_o, almost_* and standard-mode empty_o update on the edge after the accepted access (1 cycle).
- **Standard read latency:** rd_data_o is valid 1 cycle after the accepted rd_en_i.
- **FWFT write-to-read latency:** write into an empty FIFO gives rd_valid_o 2 cycles after the write edge (RAM read + output register).
- **Throughput:** 1 write and 1 read per cycle sustained in both modes.

## Structure
- The shared package holds:
  - the complex-sample width constant (2*DATA_WIDTH);
  - I/Q slice positions (I upper, Q lower);
  - the default CH_WIDTH.
- One sub-module: iq_fifo_ram, a simple dual-port RAM.
  - Parameters ADDR_WIDTH and WIDTH = 2*DATA_WIDTH+CH_WIDTH.
  - Registered read, no reset, write-first not required.
  - Maps to block RAM.
- Pointer, level, flag and FWFT prefetch logic live in iq_sync_fifo.

## Test plan
- **Reset:** assert rst_b_i mid-stream with level_o=5 (FWFT=0) -> all outputs at reset values asynchronously. Next write of 0x1111_2222 ch=1 is the first word read back.
- **Fill/drain:** write 1024 words (ADDR_WIDTH=10) -> full_o=1 and level_o=1024 one cycle after the last write. The 1025th write sets overflow_o and level stays 1024. Drain -> data in order, empty_o=1, and a further read sets underflow_o.
- **Simultaneous access:** at level 1, read+write in the same cycle -> level_o stays 1, empty_o stays 0. At level 0 (FWFT=0), read+write -> write accepted, read rejected, underflow_o=1, level_o=1.
- **Thresholds:** af_thresh=768, ae_thresh=16 -> almost_empty_o falls on the cycle level_o goes 16->17. almost_full_o rises when level_o reaches 768, falls at 767.
- **FWFT latency:** FWFT=1, single write 0xA5A5_5A5A ch=3 -> rd_valid_o=1 two cycles later with that data and tag. Continuous pops of a burst of 8 -> 8 consecutive valid cycles with no bubble.
- **Sticky-flag clear:** clr_flags_i in the same cycle as an overflowing write -> overflow_o remains 1. clr_flags_i alone -> overflow_o and underflow_o clear the next cycle.
